// File: rtl/mips_multicycle_control_if.sv
// rtl/mips_multicycle_control_if.sv - control/datapath signal bundle for the multicycle MIPS controller
//
// master: the controller (consumes instruction fields and status, drives select/enable lines)
// slave : the datapath (drives instruction fields and status, consumes select/enable lines)
//   OP[5:0], Funct[5:0]  instruction register fields
//   Zero                 ALU zero flag
//   MemReady             memory access done (handshake builds only)
//   PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst[1:0], MemtoReg[1:0], RegWrite,
//   ALUSrcA, ALUSrcB[1:0], ALUOp[2:0], PCSource[1:0]   datapath controls
//   IllegalOp            one-cycle pulse on an unsupported opcode
//   State[3:0]           current controller state (debug)
interface mips_multicycle_control_if;
    logic [5:0] OP;
    logic [5:0] Funct;
    logic       Zero;
    logic       MemReady;
    logic       PCWrite;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic [1:0] RegDst;
    logic [1:0] MemtoReg;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUOp;
    logic [1:0] PCSource;
    logic       IllegalOp;
    logic [3:0] State;

    modport master (
        input  OP, Funct, Zero, MemReady,
        output PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
               ALUSrcA, ALUSrcB, ALUOp, PCSource, IllegalOp, State
    );

    modport slave (
        output OP, Funct, Zero, MemReady,
        input  PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
               ALUSrcA, ALUSrcB, ALUOp, PCSource, IllegalOp, State
    );
endinterface

// File: rtl/mips_multicycle_control.sv
// rtl/mips_multicycle_control.sv - multicycle MIPS control FSM with wait-state or handshake memory stalls
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset; returns the FSM to FETCH and clears the wait counter
//   bus    mips_multicycle_control_if.master: instruction fields/status in, datapath controls out
// Parameters:
//   MEM_HANDSHAKE  0: memory access completes after WAIT_STATES extra cycles; 1: completes on MemReady
//   WAIT_STATES    extra cycles per memory access in fixed-wait mode (0..15)
module mips_multicycle_control #(
    parameter int MEM_HANDSHAKE = 0,
    parameter int WAIT_STATES   = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    mips_multicycle_control_if.master     bus
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_IEXEC  = 4'd10,
        S_IWB    = 4'd11,
        S_JAL    = 4'd12,
        S_JR     = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_JR    = 6'h08;

    localparam logic [2:0] ALU_ADD   = 3'd0;
    localparam logic [2:0] ALU_SUB   = 3'd1;
    localparam logic [2:0] ALU_FUNCT = 3'd2;
    localparam logic [2:0] ALU_OR    = 3'd3;
    localparam logic [2:0] ALU_AND   = 3'd4;
    localparam logic [2:0] ALU_LUI   = 3'd5;

    localparam logic [3:0] WAIT_LAST = 4'(WAIT_STATES);

    state_t     state;
    state_t     next_state;
    logic [3:0] wait_cnt;
    logic       in_mem;
    logic       done;

    // States that own the memory port and therefore stall.
    assign in_mem = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);

    // MemReady outside a memory state never matters: done is only consumed by memory states.
    assign done = (MEM_HANDSHAKE != 0) ? bus.MemReady : (wait_cnt == WAIT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_FETCH;
            wait_cnt <= '0;
        end else begin
            state <= next_state;
            // Counts stall cycles of the current access; the access ends on done, so the
            // counter is back at zero before the next memory state begins.
            if ((MEM_HANDSHAKE == 0) && in_mem && !done) begin
                wait_cnt <= wait_cnt + 4'd1;
            end else begin
                wait_cnt <= '0;
            end
        end
    end

    always_comb begin
        next_state    = state;
        bus.PCWrite   = 1'b0;
        bus.IorD      = 1'b0;
        bus.MemRead   = 1'b0;
        bus.MemWrite  = 1'b0;
        bus.IRWrite   = 1'b0;
        bus.RegDst    = 2'd0;
        bus.MemtoReg  = 2'd0;
        bus.RegWrite  = 1'b0;
        bus.ALUSrcA   = 1'b0;
        bus.ALUSrcB   = 2'd0;
        bus.ALUOp     = ALU_ADD;
        bus.PCSource  = 2'd0;
        bus.IllegalOp = 1'b0;

        unique case (state)
            S_FETCH: begin
                // PC + 4 is computed by the ALU and written back in the same done cycle.
                bus.MemRead = 1'b1;
                bus.ALUSrcB = 2'd1;
                bus.IRWrite = done;
                bus.PCWrite = done;
                if (done) next_state = S_DECODE;
            end
            S_DECODE: begin
                // Speculatively compute the branch target into ALUOut.
                bus.ALUSrcB = 2'd3;
                unique case (bus.OP)
                    OP_LW, OP_SW:                     next_state = S_MEMADR;
                    OP_RTYPE:                         next_state = (bus.Funct == FN_JR) ? S_JR : S_EXEC;
                    OP_BEQ, OP_BNE:                   next_state = S_BRANCH;
                    OP_J:                             next_state = S_JUMP;
                    OP_JAL:                           next_state = S_JAL;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: next_state = S_IEXEC;
                    default: begin
                        bus.IllegalOp = 1'b1;
                        next_state    = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'd2;
                next_state  = (bus.OP == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                bus.MemRead = 1'b1;
                bus.IorD    = 1'b1;
                if (done) next_state = S_MEMWB;
            end
            S_MEMWB: begin
                bus.MemtoReg = 2'd1;
                bus.RegWrite = 1'b1;
                next_state   = S_FETCH;
            end
            S_MEMWR: begin
                bus.MemWrite = 1'b1;
                bus.IorD     = 1'b1;
                if (done) next_state = S_FETCH;
            end
            S_EXEC: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUOp   = ALU_FUNCT;
                next_state  = S_RWB;
            end
            S_RWB: begin
                bus.RegDst   = 2'd1;
                bus.RegWrite = 1'b1;
                next_state   = S_FETCH;
            end
            S_BRANCH: begin
                bus.ALUSrcA  = 1'b1;
                bus.ALUOp    = ALU_SUB;
                bus.PCSource = 2'd1;
                bus.PCWrite  = ((bus.OP == OP_BEQ) && bus.Zero) || ((bus.OP == OP_BNE) && !bus.Zero);
                next_state   = S_FETCH;
            end
            S_JUMP: begin
                bus.PCSource = 2'd2;
                bus.PCWrite  = 1'b1;
                next_state   = S_FETCH;
            end
            S_IEXEC: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'd2;
                unique case (bus.OP)
                    OP_ANDI: bus.ALUOp = ALU_AND;
                    OP_ORI:  bus.ALUOp = ALU_OR;
                    OP_LUI:  bus.ALUOp = ALU_LUI;
                    default: bus.ALUOp = ALU_ADD;
                endcase
                next_state = S_IWB;
            end
            S_IWB: begin
                bus.RegWrite = 1'b1;
                next_state   = S_FETCH;
            end
            S_JAL: begin
                // PC already holds PC + 4 from FETCH, so it is the link value.
                bus.RegDst   = 2'd2;
                bus.MemtoReg = 2'd2;
                bus.RegWrite = 1'b1;
                bus.PCSource = 2'd2;
                bus.PCWrite  = 1'b1;
                next_state   = S_FETCH;
            end
            S_JR: begin
                bus.PCSource = 2'd3;
                bus.PCWrite  = 1'b1;
                next_state   = S_FETCH;
            end
            default: next_state = S_FETCH;
        endcase

        // An access cut short by reset must not commit any architectural state.
        if (reset) begin
            bus.PCWrite  = 1'b0;
            bus.IRWrite  = 1'b0;
            bus.RegWrite = 1'b0;
        end
    end

    assign bus.State = state;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// tb/tb_mips_multicycle_control.sv - scoreboard bench for mips_multicycle_control in three memory-timing builds
module tb_mips_multicycle_control;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw;
        logic       iord;
        logic       mrd;
        logic       mwr;
        logic       irw;
        logic [1:0] rdst;
        logic [1:0] m2r;
        logic       rw;
        logic       asa;
        logic [1:0] asb;
        logic [2:0] aop;
        logic [1:0] pcs;
        logic       ill;
    } ctl_t;

    logic       clk;
    logic       reset;
    logic [5:0] op_d;
    logic [5:0] funct_d;
    logic       zero_d;
    logic       ready_d;
    int         sel;
    int         ws;
    bit         hs;

    ctl_t       exp_q[$];
    string      name_q[$];
    string      path_q[$];
    int         n_checks;
    int         n_fail;

    mips_multicycle_control_if if0 ();
    mips_multicycle_control_if if1 ();
    mips_multicycle_control_if if2 ();

    assign if0.OP = op_d;  assign if0.Funct = funct_d;  assign if0.Zero = zero_d;  assign if0.MemReady = ready_d;
    assign if1.OP = op_d;  assign if1.Funct = funct_d;  assign if1.Zero = zero_d;  assign if1.MemReady = ready_d;
    assign if2.OP = op_d;  assign if2.Funct = funct_d;  assign if2.Zero = zero_d;  assign if2.MemReady = ready_d;

    mips_multicycle_control #(.MEM_HANDSHAKE(0), .WAIT_STATES(0)) u_dut_ws0 (.clk(clk), .reset(reset), .bus(if0));
    mips_multicycle_control #(.MEM_HANDSHAKE(0), .WAIT_STATES(2)) u_dut_ws2 (.clk(clk), .reset(reset), .bus(if1));
    mips_multicycle_control #(.MEM_HANDSHAKE(1), .WAIT_STATES(0)) u_dut_hs  (.clk(clk), .reset(reset), .bus(if2));

    ctl_t obs0, obs1, obs2, obs;
    assign obs0 = {if0.State, if0.PCWrite, if0.IorD, if0.MemRead, if0.MemWrite, if0.IRWrite, if0.RegDst,
                   if0.MemtoReg, if0.RegWrite, if0.ALUSrcA, if0.ALUSrcB, if0.ALUOp, if0.PCSource, if0.IllegalOp};
    assign obs1 = {if1.State, if1.PCWrite, if1.IorD, if1.MemRead, if1.MemWrite, if1.IRWrite, if1.RegDst,
                   if1.MemtoReg, if1.RegWrite, if1.ALUSrcA, if1.ALUSrcB, if1.ALUOp, if1.PCSource, if1.IllegalOp};
    assign obs2 = {if2.State, if2.PCWrite, if2.IorD, if2.MemRead, if2.MemWrite, if2.IRWrite, if2.RegDst,
                   if2.MemtoReg, if2.RegWrite, if2.ALUSrcA, if2.ALUSrcB, if2.ALUOp, if2.PCSource, if2.IllegalOp};

    always_comb begin
        obs = obs0;
        if (sel == 1) obs = obs1;
        else if (sel == 2) obs = obs2;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected controls for one cycle of a named step of an instruction.
    function automatic ctl_t expect_step(string step, logic [5:0] op, logic zero, logic done);
        ctl_t e;
        e = '0;
        case (step)
            "fetch":  begin e.st = 0;  e.mrd = 1; e.asb = 1; e.irw = done; e.pcw = done; end
            "decode": begin
                e.st = 1; e.asb = 3;
                e.ill = !(op inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B});
            end
            "memadr": begin e.st = 2;  e.asa = 1; e.asb = 2; end
            "memrd":  begin e.st = 3;  e.mrd = 1; e.iord = 1; end
            "memwb":  begin e.st = 4;  e.m2r = 1; e.rw = 1; end
            "memwr":  begin e.st = 5;  e.mwr = 1; e.iord = 1; end
            "exec":   begin e.st = 6;  e.asa = 1; e.aop = 2; end
            "rwb":    begin e.st = 7;  e.rdst = 1; e.rw = 1; end
            "branch": begin
                e.st = 8; e.asa = 1; e.aop = 1; e.pcs = 1;
                e.pcw = (op == 6'h04) ? zero : !zero;
            end
            "jump":   begin e.st = 9;  e.pcs = 2; e.pcw = 1; end
            "iexec":  begin
                e.st = 10; e.asa = 1; e.asb = 2;
                e.aop = (op == 6'h0C) ? 3'd4 : (op == 6'h0D) ? 3'd3 : (op == 6'h0F) ? 3'd5 : 3'd0;
            end
            "iwb":    begin e.st = 11; e.rw = 1; end
            "jal":    begin e.st = 12; e.rdst = 2; e.m2r = 2; e.rw = 1; e.pcs = 2; e.pcw = 1; end
            "jr":     begin e.st = 13; e.pcs = 3; e.pcw = 1; end
            default:  e = '1;
        endcase
        return e;
    endfunction

    // Step sequence an instruction walks through, one entry per architectural phase.
    function automatic void build_path(logic [5:0] op, logic [5:0] funct);
        path_q.delete();
        path_q.push_back("fetch");
        path_q.push_back("decode");
        case (op)
            6'h23: begin path_q.push_back("memadr"); path_q.push_back("memrd"); path_q.push_back("memwb"); end
            6'h2B: begin path_q.push_back("memadr"); path_q.push_back("memwr"); end
            6'h00: begin
                if (funct == 6'h08) path_q.push_back("jr");
                else begin path_q.push_back("exec"); path_q.push_back("rwb"); end
            end
            6'h04, 6'h05: path_q.push_back("branch");
            6'h02: path_q.push_back("jump");
            6'h03: path_q.push_back("jal");
            6'h08, 6'h0C, 6'h0D, 6'h0F: begin path_q.push_back("iexec"); path_q.push_back("iwb"); end
            default: ;
        endcase
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            ctl_t  e;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL ctl_%s dut%0d t=%0t: got st=%0d ctl=%h, expected st=%0d ctl=%h",
                         nm, sel, $time, obs.st, obs, e.st, e);
            end
        end
    end

    task automatic cycle(string step, logic [5:0] op, logic [5:0] funct, logic zero, logic ready, logic done);
        op_d    = op;
        funct_d = funct;
        zero_d  = zero;
        ready_d = ready;
        exp_q.push_back(expect_step(step, op, zero, done));
        name_q.push_back(step);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Runs one instruction; min_stall forces MemReady low for that many cycles of each
    // handshake access before random completion.
    task automatic run_instr(logic [5:0] op, logic [5:0] funct, logic zero, int min_stall);
        string steps[$];
        build_path(op, funct);
        steps = path_q;
        foreach (steps[i]) begin
            if (steps[i] == "fetch" || steps[i] == "memrd" || steps[i] == "memwr") begin
                if (hs) begin
                    bit rdy;
                    int n;
                    n = 0;
                    do begin
                        rdy = (n >= min_stall) && ((n >= min_stall + 4) || ($urandom_range(1, 0) == 1));
                        cycle(steps[i], op, funct, zero, rdy, rdy);
                        n++;
                    end while (!rdy);
                end else begin
                    for (int w = 0; w <= ws; w++)
                        cycle(steps[i], op, funct, zero, 1'($urandom_range(1, 0)), w == ws);
                end
            end else begin
                cycle(steps[i], op, funct, zero, 1'($urandom_range(1, 0)), 1'b0);
            end
        end
    endtask

    task automatic run_random(int count);
        logic [5:0] ops[14];
        ops = '{6'h23, 6'h2B, 6'h00, 6'h00, 6'h04, 6'h05, 6'h02, 6'h03,
                6'h08, 6'h0C, 6'h0D, 6'h0F, 6'h3F, 6'h01};
        for (int k = 0; k < count; k++) begin
            logic [5:0] op, fn;
            op = ops[$urandom_range(13, 0)];
            if (op == 6'h01) op = 6'h10 + 6'($urandom_range(15, 0));
            fn = ($urandom_range(3, 0) == 0) ? 6'h08 : 6'($urandom_range(63, 0));
            run_instr(op, fn, 1'($urandom_range(1, 0)), 0);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        op_d     = 6'h00;
        funct_d  = 6'h20;
        zero_d   = 1'b0;
        ready_d  = 1'b0;

        // Fixed timing, no wait states.
        sel = 0; ws = 0; hs = 0;
        do_reset();
        run_instr(6'h23, 6'h00, 1'b0, 0);
        run_instr(6'h2B, 6'h00, 1'b0, 0);
        run_instr(6'h04, 6'h00, 1'b1, 0);
        run_instr(6'h05, 6'h00, 1'b1, 0);
        run_instr(6'h05, 6'h00, 1'b0, 0);
        run_instr(6'h03, 6'h00, 1'b0, 0);
        run_instr(6'h00, 6'h08, 1'b0, 0);
        run_instr(6'h3F, 6'h00, 1'b0, 0);
        run_instr(6'h0F, 6'h00, 1'b0, 0);
        run_random(40);

        // Two wait states per access, including a reset during a stalled load read.
        sel = 1; ws = 2; hs = 0;
        do_reset();
        run_instr(6'h2B, 6'h00, 1'b0, 0);
        for (int w = 0; w <= 2; w++) cycle("fetch", 6'h23, 6'h00, 1'b0, 1'b0, w == 2);
        cycle("decode", 6'h23, 6'h00, 1'b0, 1'b0, 1'b0);
        cycle("memadr", 6'h23, 6'h00, 1'b0, 1'b0, 1'b0);
        cycle("memrd",  6'h23, 6'h00, 1'b0, 1'b1, 1'b0);
        reset = 1'b1;
        cycle("memrd",  6'h23, 6'h00, 1'b0, 1'b1, 1'b0);
        reset = 1'b0;
        run_instr(6'h23, 6'h00, 1'b0, 0);
        run_random(25);

        // Ready handshake, with a five-cycle stall on the first fetch.
        sel = 2; ws = 0; hs = 1;
        do_reset();
        run_instr(6'h08, 6'h00, 1'b0, 5);
        run_instr(6'h23, 6'h00, 1'b0, 2);
        run_instr(6'h2B, 6'h00, 1'b0, 3);
        run_random(25);

        @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
